// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e     : converter FSM states (ST_IDLE, ST_SHIFT, ST_DONE)
//   bcd_digits  : number of BCD digits needed to hold 2^width-1
//   clog2       : ceiling log2, used for counter and digit-count widths
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // log10(2) ~= 0.301, so width*0.301 digits plus one covers 2^width-1.
    function automatic int bcd_digits(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
//   digit_i : BCD digit before correction
//   digit_o : corrected digit (combinational)
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/seq_binary_to_bcd.sv
// Multi-cycle binary-to-BCD converter (double dabble), one input bit per clock.
// Optional two's-complement input; reports sign and significant-digit count.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : in_data/in_signed valid
//   in_ready     : converter can accept a word
//   in_data      : binary operand
//   in_signed    : treat in_data as two's complement
//   out_valid    : result valid
//   out_ready    : downstream accepts the result
//   out_bcd      : packed BCD, [3:0] = units
//   out_neg      : result is negative
//   out_ndigits  : significant digit count (1 for zero, 0 while !out_valid)
module seq_binary_to_bcd
    import bcd_pkg::*;
#(
    parameter  int BIN_WIDTH = 16,
    localparam int DIGITS    = bcd_digits(BIN_WIDTH),
    localparam int NDW       = clog2(DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_WIDTH-1:0]  in_data,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_neg,
    output logic [NDW-1:0]        out_ndigits
);

    localparam int CNTW = clog2(BIN_WIDTH + 1);

    state_e                state_q, state_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]  mag_q, mag_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  neg_q, neg_d;
    logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
    logic                  out_neg_q, out_neg_d;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic                  accept;
    logic                  in_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign in_neg   = in_signed & in_data[BIN_WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        out_bcd_d = out_bcd_q;
        out_neg_d = out_neg_q;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d          = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    // Publish on the final shift so out_bcd only moves as out_valid rises.
                    state_d   = ST_DONE;
                    out_bcd_d = {bcd_adj[4*DIGITS-2:0], mag_q[BIN_WIDTH-1]};
                    out_neg_d = neg_q;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance overrides the DONE->IDLE exit for back-to-back words.
        if (accept) begin
            state_d = ST_SHIFT;
            cnt_d   = CNTW'(BIN_WIDTH);
            // Negation is modulo 2^BIN_WIDTH, so the most-negative value maps to 2^(BIN_WIDTH-1).
            mag_d   = in_neg ? ((~in_data) + BIN_WIDTH'(1)) : in_data;
            neg_d   = in_neg;
            bcd_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            out_bcd_q <= '0;
            out_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            out_bcd_q <= out_bcd_d;
            out_neg_q <= out_neg_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign out_bcd   = out_bcd_q;
    assign out_neg   = out_neg_q;

    // Highest nonzero digit index + 1; units digit always counts.
    always_comb begin
        out_ndigits = '0;
        if (state_q == ST_DONE) begin
            out_ndigits = NDW'(1);
            for (int i = 1; i < DIGITS; i++) begin
                if (out_bcd_q[4*i +: 4] != 4'd0) out_ndigits = NDW'(i + 1);
            end
        end
    end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
module tb_seq_binary_to_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [79:0] bcd;
        logic        neg;
        logic [7:0]  nd;
    } res_t;

    // Reference: signed/unsigned value to decimal digits by plain arithmetic.
    function automatic res_t model(input logic [63:0] data, input bit s, input int w);
        res_t r;
        logic [63:0] v;
        r.neg = s && data[w-1];
        v     = r.neg ? ((64'd1 << w) - data) : data;
        r.bcd = '0;
        r.nd  = 8'd1;
        for (int i = 0; i < 20; i++) begin
            r.bcd[4*i +: 4] = 4'(v % 10);
            if ((v % 10) != 0) r.nd = 8'(i + 1);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [79:0] b);
        for (int i = 0; i < 20; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // 16-bit instance
    logic        rst16, iv16, ir16, is16, ov16, or16, neg16;
    logic [15:0] id16;
    logic [19:0] bcd16;
    logic [2:0]  nd16;

    seq_binary_to_bcd #(.BIN_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
        .in_signed(is16), .out_valid(ov16), .out_ready(or16), .out_bcd(bcd16),
        .out_neg(neg16), .out_ndigits(nd16)
    );

    // 8-bit instance
    logic        rst8, iv8, ir8, is8, ov8, or8, neg8;
    logic [7:0]  id8;
    logic [11:0] bcd8;
    logic [1:0]  nd8;

    seq_binary_to_bcd #(.BIN_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_signed(is8), .out_valid(ov8), .out_ready(or8), .out_bcd(bcd8),
        .out_neg(neg8), .out_ndigits(nd8)
    );

    a_dig16: assert property (@(posedge clk) disable iff (rst16) ov16 |-> bcd_ok({60'd0, bcd16}))
        else begin n_err++; $display("FAIL digit16 >9: bcd %0h", bcd16); end
    a_dig8: assert property (@(posedge clk) disable iff (rst8) ov8 |-> bcd_ok({68'd0, bcd8}))
        else begin n_err++; $display("FAIL digit8 >9: bcd %0h", bcd8); end

    // Scoreboard for the 8-bit randomized run
    res_t q8[$];
    int   got8 = 0;
    bit   run8 = 1'b0;

    always @(negedge clk) begin
        if (run8) begin
            if (ov8) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL w8 unexpected result: got %0h expected none", bcd8);
                end else begin
                    chk("w8 bcd", {68'd0, bcd8}, q8[0].bcd);
                    chk("w8 neg", {79'd0, neg8}, {79'd0, q8[0].neg});
                    chk("w8 ndigits", {78'd0, nd8}, {72'd0, q8[0].nd});
                    if (or8) begin
                        void'(q8.pop_front());
                        got8++;
                    end
                end
            end else begin
                chk("w8 ndigits idle", {78'd0, nd8}, 80'd0);
            end
            if (iv8 && ir8) q8.push_back(model({56'd0, id8}, is8, 8));
        end
    end

    task automatic wait16(output int n);
        n = 0;
        while (!ov16 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Present one word, check latency and result; leaves result held (or16=0).
    task automatic run16(input logic [15:0] d, input bit s, input bit has_lit,
                         input logic [19:0] eb, input bit en, input int end_, input string tag);
        res_t m;
        int   n;
        @(posedge clk); #1;
        iv16 = 1'b1; id16 = d; is16 = s;
        #1;
        chk({tag, " in_ready"}, {79'd0, ir16}, 80'd1);
        @(posedge clk); #1;
        iv16 = 1'b0; id16 = 16'($urandom); is16 = 1'($urandom);
        wait16(n);
        chk({tag, " latency"}, 80'(n), 80'd16);
        m = model({48'd0, d}, s, 16);
        chk({tag, " bcd_model"}, {60'd0, bcd16}, m.bcd);
        chk({tag, " nd_model"}, {77'd0, nd16}, {72'd0, m.nd});
        chk({tag, " neg_model"}, {79'd0, neg16}, {79'd0, m.neg});
        if (has_lit) begin
            chk({tag, " bcd"}, {60'd0, bcd16}, {60'd0, eb});
            chk({tag, " neg"}, {79'd0, neg16}, {79'd0, en});
            chk({tag, " ndigits"}, {77'd0, nd16}, 80'(end_));
        end
    endtask

    task automatic release16(input string tag);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        chk({tag, " valid drop"}, {79'd0, ov16}, 80'd0);
    endtask

    initial begin
        int n, idx, guard;
        bit acc;
        rst16 = 1'b1; iv16 = 1'b0; id16 = '0; is16 = 1'b0; or16 = 1'b0;
        rst8  = 1'b1; iv8  = 1'b0; id8  = '0; is8  = 1'b0; or8  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst16 = 1'b0;
        chk("rst out_valid", {79'd0, ov16}, 80'd0);
        chk("rst out_bcd", {60'd0, bcd16}, 80'd0);
        chk("rst out_neg", {79'd0, neg16}, 80'd0);
        chk("rst in_ready", {79'd0, ir16}, 80'd1);
        chk("rst ndigits", {77'd0, nd16}, 80'd0);

        run16(16'd65535, 1'b0, 1'b1, 20'h65535, 1'b0, 5, "u65535"); release16("u65535");
        run16(16'hFFFF,  1'b1, 1'b1, 20'h00001, 1'b1, 1, "sFFFF");  release16("sFFFF");
        run16(16'h8000,  1'b1, 1'b1, 20'h32768, 1'b1, 5, "s8000");  release16("s8000");
        run16(16'd0,     1'b1, 1'b1, 20'h00000, 1'b0, 1, "s0");     release16("s0");
        run16(16'd0,     1'b0, 1'b1, 20'h00000, 1'b0, 1, "u0");     release16("u0");
        run16(16'd10,    1'b0, 1'b1, 20'h00010, 1'b0, 2, "u10");    release16("u10");
        for (int k = 0; k < 4; k++) begin
            run16(16'($urandom), 1'($urandom), 1'b0, 20'd0, 1'b0, 0, "rnd16");
            release16("rnd16");
        end

        // Backpressure then same-cycle accept of the next word
        run16(16'd1234, 1'b0, 1'b1, 20'h01234, 1'b0, 4, "bp1234");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp hold bcd", {60'd0, bcd16}, 80'h01234);
            chk("bp hold valid", {79'd0, ov16}, 80'd1);
            chk("bp in_ready", {79'd0, ir16}, 80'd0);
        end
        or16 = 1'b1; iv16 = 1'b1; id16 = 16'd42; is16 = 1'b0;
        #1;
        chk("b2b in_ready", {79'd0, ir16}, 80'd1);
        @(posedge clk); #1;
        or16 = 1'b0; iv16 = 1'b0;
        chk("b2b valid drop", {79'd0, ov16}, 80'd0);
        wait16(n);
        chk("b2b latency", 80'(n), 80'd16);
        chk("b2b bcd", {60'd0, bcd16}, 80'h00042);
        chk("b2b ndigits", {77'd0, nd16}, 80'd2);
        release16("b2b");

        // Reset in the middle of a conversion
        @(posedge clk); #1;
        iv16 = 1'b1; id16 = 16'd5555; is16 = 1'b0;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst16 = 1'b1;
        @(posedge clk); #1;
        rst16 = 1'b0;
        chk("midrst out_valid", {79'd0, ov16}, 80'd0);
        chk("midrst out_bcd", {60'd0, bcd16}, 80'd0);
        chk("midrst in_ready", {79'd0, ir16}, 80'd1);
        run16(16'd9876, 1'b0, 1'b1, 20'h09876, 1'b0, 4, "postrst"); release16("postrst");

        // 8-bit exhaustive, both modes, random stalls on both sides
        #1 rst8 = 1'b0;
        run8 = 1'b1;
        idx = 0; guard = 0; acc = 1'b0;
        while (idx < 512 && guard < 30000) begin
            @(posedge clk); #1;
            guard++;
            if (acc) begin iv8 = 1'b0; acc = 1'b0; end
            or8 = ($urandom_range(0, 3) != 0);
            if (!iv8 && $urandom_range(0, 3) != 0) begin
                iv8 = 1'b1; id8 = idx[7:0]; is8 = idx[8];
            end
            #1;
            if (iv8 && ir8) begin acc = 1'b1; idx++; end
        end
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b1;
        guard = 0;
        while ((q8.size() != 0 || ov8) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1 run8 = 1'b0;
        chk("w8 words sent", 80'(idx), 80'd512);
        chk("w8 results", 80'(got8), 80'd512);
        chk("w8 sb empty", 80'(q8.size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
